ov_capture_ctrl: RTL
====================

# ov_capture_ctrl

Capture sequencer for the OV camera input path. It consumes the clk_sys-domain byte stream and sync qualifiers produced by the camera monitor. On a host command it arms, waits for a frame boundary, and extracts a configurable rectangular window. It packs byte pairs into 16-bit words and drives a linear write port into the frame buffer, reporting completion and short-frame errors.

## Interface
- AW, 18, frame-buffer word-address width
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_start  in  1  single-cycle pulse; arm a capture
- cmd_abort  in  1  single-cycle pulse; cancel capture
- cfg_x_start  in  12  first captured byte within a line; bit 0 ignored, treated as 0
- cfg_x_len  in  12  bytes per captured line; bit 0 ignored; 0 means no bytes
- cfg_y_start  in  11  first captured line, 0-based
- cfg_y_len  in  11  captured line count; 0 completes at frame start
- ov_vs  in  1  filtered vsync; high = vertical blank
- ov_href  in  1  line-valid, synchronised to clk_sys
- data_pclk  in  8  sampled pixel byte
- data_vld  in  1  one-cycle strobe; data_pclk is valid this cycle
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  AW  word address
- wr_data  out  16  {first byte, second byte}
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- frame_err  out  1  sticky; frame ended before the window completed; cleared by cmd_start
- word_cnt  out  AW  words written in the current or last capture

## Operation
- cfg_* is latched on an accepted cmd_start. Changes to cfg_* during a capture have no effect.
- States and transitions:
  - IDLE: on cmd_start, go to WAIT_BLANK. In the same cycle, clear word_cnt, wr_addr and frame_err.
  - WAIT_BLANK: when ov_vs=1, go to WAIT_SOF. This prevents starting mid-frame.
  - WAIT_SOF: on the ov_vs falling edge, go to CAPTURE. In the same cycle, line_cnt=0 and byte_cnt=0. If y_len=0, go to DONE instead.
  - CAPTURE:
    - byte_cnt clears on the ov_href rising edge and increments on each data_vld while ov_href=1.
    - line_cnt increments on the ov_href falling edge.
    - A byte is in-window when y_start ≤ line_cnt < y_start+y_len and x_start ≤ byte_cnt < x_start+x_len.
    - The first in-window byte of a pair is held in a pair register. The second byte produces a write.
    - Leave for DONE on the ov_href falling edge where line_cnt = y_start+y_len-1.
    - If the ov_vs rising edge arrives first, go to DONE with frame_err=1.
  - DONE: assert done for one cycle, then return to IDLE.
- Window arithmetic is 13 bits (12 bits for y), so x_start+x_len and y_start+y_len cannot overflow.
- A window extending past the actual line length yields fewer words. This is not an error.
- A half-filled pair at a line end is discarded. No pair spans lines.
- wr_addr starts at 0 and increments after each write, wrapping modulo 2^AW. word_cnt tracks wr_addr.
- cmd_start is ignored while busy=1.
- cmd_abort in any state forces IDLE on the next edge. No done pulse is produced, and word_cnt holds its value.
- If cmd_start and cmd_abort arrive in the same cycle, abort wins.
- Reset mid-capture returns the block to IDLE immediately. All outputs take their reset values.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, frame_err=0, word_cnt=0.
- All outputs are registered.
- wr_en and wr_data appear one clk_sys cycle after the data_vld of the second byte of a pair.
- wr_addr is valid with wr_en and advances on the following edge.
- busy rises the cycle after cmd_start.
- done rises the cycle after the terminating href or ov_vs edge and lasts exactly 1 cycle. busy falls together with done.
- The final write's wr_en is never later than done.
- Edge detection uses a one-cycle delayed copy of ov_vs and ov_href. An edge is acted on in the cycle it is detected.
- The minimum data_vld spacing is 2 clk_sys cycles, so no write back-pressure exists.

## Test plan
- Basic window: x_start=4, x_len=8, y_start=2, y_len=3; frame with 5 lines of 16 bytes each, bytes = byte index.
  - Required: 12 writes to addresses 0..11, first wr_data=16'h0405.
  - Required: done once, frame_err=0, word_cnt=12.
- Arm mid-frame: cmd_start while ov_vs=0 and lines are active.
  - Required: no writes until a full blank, then the next frame's falling edge.
  - Required: capture content is from that next frame only.
- Short frame: y_start=0, y_len=10; the frame has 4 lines of 8 bytes and full window.
  - Required: 16 words, done on the ov_vs rise, frame_err=1.
- Abort: cmd_abort after 3 writes.
  - Required: busy=0 next cycle, no done pulse, word_cnt=3, no further wr_en.
- Odd config and overrun: x_start=3, x_len=5, treated as x_start=2, x_len=4; line of 3 bytes.
  - Required: 0 writes for that line; the trailing half pair is discarded.
- Simultaneous and reset: cmd_start with cmd_abort → stays IDLE. rst_n low mid-CAPTURE → all outputs 0 at once; the next cmd_start operates normally.

Source files
------------

// File: rtl/ov_capture_ctrl.sv
// Capture sequencer for the OV camera path: arms on command, waits for a frame
// boundary, extracts a byte window and writes packed 16-bit words to the frame buffer.
module ov_capture_ctrl #(
  parameter int AW = 18
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          cmd_start,
  input  logic          cmd_abort,
  input  logic [11:0]   cfg_x_start,
  input  logic [11:0]   cfg_x_len,
  input  logic [10:0]   cfg_y_start,
  input  logic [10:0]   cfg_y_len,
  input  logic          ov_vs,
  input  logic          ov_href,
  input  logic [7:0]    data_pclk,
  input  logic          data_vld,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic          frame_err,
  output logic [AW-1:0] word_cnt
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_BLANK = 3'd1;
  localparam logic [2:0] WAIT_SOF   = 3'd2;
  localparam logic [2:0] CAPTURE    = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  logic [2:0]    r_state;
  logic          r_vs_d, r_href_d;
  logic          r_busy, r_done, r_frame_err, r_wr_en;
  logic [AW-1:0] r_wr_addr, r_word_cnt;
  logic [15:0]   r_wr_data;
  logic [7:0]    r_pair;
  logic          r_pair_vld;
  logic [11:0]   r_x_start;
  logic [12:0]   r_x_end;
  logic [10:0]   r_y_start;
  logic [11:0]   r_y_end;
  logic [12:0]   r_byte_cnt;
  logic [11:0]   r_line_cnt;

  logic [2:0]  w_state_nxt;
  logic        w_write, w_pair_load, w_err_set, w_accept;
  logic        w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
  logic [12:0] w_byte_idx;
  logic        w_in_win, w_last_line;
  logic [11:0] w_cfg_x_start, w_cfg_x_len;

  assign w_vs_rise   = ov_vs & ~r_vs_d;
  assign w_vs_fall   = ~ov_vs & r_vs_d;
  assign w_href_rise = ov_href & ~r_href_d;
  assign w_href_fall = ~ov_href & r_href_d;

  // Horizontal window is always pair-aligned; odd start/length bits are dropped.
  assign w_cfg_x_start = cfg_x_start & ~12'd1;
  assign w_cfg_x_len   = cfg_x_len & ~12'd1;

  // A byte arriving in the same cycle as the href rise is byte 0 of the new line.
  assign w_byte_idx  = w_href_rise ? 13'd0 : r_byte_cnt;
  assign w_in_win    = ov_href && data_vld
                    && (w_byte_idx >= {1'b0, r_x_start}) && (w_byte_idx < r_x_end)
                    && (r_line_cnt >= {1'b0, r_y_start}) && (r_line_cnt < r_y_end);
  assign w_last_line = (r_line_cnt == r_y_end - 12'd1);
  assign w_accept    = (r_state == IDLE) && cmd_start && !cmd_abort;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_pair_load = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE:       if (cmd_start) w_state_nxt = WAIT_BLANK;
      WAIT_BLANK: if (ov_vs) w_state_nxt = WAIT_SOF;
      WAIT_SOF:   if (w_vs_fall)
                    w_state_nxt = (r_y_end == {1'b0, r_y_start}) ? DONE : CAPTURE;
      CAPTURE: begin
        if (w_in_win) begin
          w_write     = r_pair_vld;
          w_pair_load = !r_pair_vld;
        end
        if (w_href_fall && w_last_line) begin
          w_state_nxt = DONE;
        end else if (w_vs_rise) begin
          w_state_nxt = DONE;
          w_err_set   = 1'b1;
        end
      end
      DONE:       w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
    if (cmd_abort) begin
      w_state_nxt = IDLE;
      w_write     = 1'b0;
      w_pair_load = 1'b0;
      w_err_set   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vs_d      <= 1'b0;
      r_href_d    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_word_cnt  <= '0;
      r_wr_data   <= '0;
      r_pair      <= '0;
      r_pair_vld  <= 1'b0;
      r_x_start   <= '0;
      r_x_end     <= '0;
      r_y_start   <= '0;
      r_y_end     <= '0;
      r_byte_cnt  <= '0;
      r_line_cnt  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vs_d   <= ov_vs;
      r_href_d <= ov_href;
      // busy drops in the same cycle done is shown.
      r_busy   <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      r_done   <= (w_state_nxt == DONE);
      r_wr_en  <= w_write;
      if (w_write)     r_wr_data <= {r_pair, data_pclk};
      if (w_pair_load) r_pair    <= data_pclk;

      if (w_accept) begin
        r_wr_addr   <= '0;
        r_word_cnt  <= '0;
        r_frame_err <= 1'b0;
        r_x_start   <= w_cfg_x_start;
        r_x_end     <= {1'b0, w_cfg_x_start} + {1'b0, w_cfg_x_len};
        r_y_start   <= cfg_y_start;
        r_y_end     <= {1'b0, cfg_y_start} + {1'b0, cfg_y_len};
      end else begin
        if (r_wr_en) begin
          r_wr_addr  <= r_wr_addr + 1'b1;
          r_word_cnt <= r_word_cnt + 1'b1;
        end
        if (w_err_set) r_frame_err <= 1'b1;
      end

      if (r_state == WAIT_SOF && w_vs_fall) begin
        r_line_cnt <= '0;
        r_byte_cnt <= '0;
        r_pair_vld <= 1'b0;
      end else if (r_state == CAPTURE) begin
        if (w_href_fall) r_line_cnt <= r_line_cnt + 12'd1;
        r_byte_cnt <= (data_vld && ov_href) ? w_byte_idx + 13'd1 : w_byte_idx;
        // A half pair never survives a line boundary.
        if (w_pair_load)                    r_pair_vld <= 1'b1;
        else if (w_write)                   r_pair_vld <= 1'b0;
        else if (w_href_rise || w_href_fall) r_pair_vld <= 1'b0;
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_err = r_frame_err;
  assign word_cnt  = r_word_cnt;

endmodule
